// File: rtl/hbridge_driver.sv
// H-bridge gate driver: two half-bridge legs, each with a dead-time FSM that
// guarantees both gates of a leg are off for DEAD_CYCLES clocks between
// complementary conductions. Gate and busy outputs are registered.

module hbridge_leg #(
  parameter int unsigned DEAD_CYCLES = 50
) (
  input  logic clk,
  input  logic clr,
  input  logic req_high_i,
  input  logic req_low_i,
  output logic h_o,
  output logic l_o,
  output logic dead_next_o
);

  localparam int unsigned CW = $clog2(DEAD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DEAD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          h_q, l_q;

  // Next-state logic: any departure from a conducting state goes through DEAD
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_OFF: begin
        if (req_high_i) begin
          state_d = S_HIGH;
        end else if (req_low_i) begin
          state_d = S_LOW;
        end else begin
          state_d = S_OFF;
        end
      end
      S_HIGH: begin
        if (req_high_i) begin
          state_d = S_HIGH;
        end else begin
          state_d = S_DEAD;
          cnt_d   = CW'(DEAD_CYCLES - 1);
        end
      end
      S_LOW: begin
        if (req_low_i) begin
          state_d = S_LOW;
        end else begin
          state_d = S_DEAD;
          cnt_d   = CW'(DEAD_CYCLES - 1);
        end
      end
      S_DEAD: begin
        // Full dead period always runs; request is only sampled on the last cycle
        if (cnt_q == {CW{1'b0}}) begin
          if (req_high_i) begin
            state_d = S_HIGH;
          end else if (req_low_i) begin
            state_d = S_LOW;
          end else begin
            state_d = S_OFF;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State, dead counter and gate registers; gates decode the state being entered
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_OFF;
      cnt_q   <= {CW{1'b0}};
      h_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= (state_d == S_HIGH);
      l_q     <= (state_d == S_LOW);
    end
  end

  assign h_o         = h_q;
  assign l_o         = l_q;
  assign dead_next_o = (state_d == S_DEAD);

endmodule

module hbridge_driver #(
  parameter int unsigned DEAD_CYCLES = 50
) (
  input  logic clk,
  input  logic clr,
  input  logic pwm,
  input  logic en,
  input  logic dir,
  input  logic brake,
  output logic ah,
  output logic al,
  output logic bh,
  output logic bl,
  output logic busy
);

  logic a_high_s, a_low_s, b_high_s, b_low_s;
  logic a_dead_next_s, b_dead_next_s;
  logic busy_q;

  // Per-cycle leg requests from the control inputs (both low = OFF)
  always_comb begin
    a_high_s = 1'b0;
    a_low_s  = 1'b0;
    b_high_s = 1'b0;
    b_low_s  = 1'b0;
    if (!en) begin
      a_low_s = 1'b0;
    end else if (brake) begin
      a_low_s = 1'b1;
      b_low_s = 1'b1;
    end else if (dir) begin
      a_high_s = pwm;
      a_low_s  = ~pwm;
      b_low_s  = 1'b1;
    end else begin
      a_low_s  = 1'b1;
      b_high_s = pwm;
      b_low_s  = ~pwm;
    end
  end

  hbridge_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_a (
    .clk         (clk),
    .clr         (clr),
    .req_high_i  (a_high_s),
    .req_low_i   (a_low_s),
    .h_o         (ah),
    .l_o         (al),
    .dead_next_o (a_dead_next_s)
  );

  hbridge_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_b (
    .clk         (clk),
    .clr         (clr),
    .req_high_i  (b_high_s),
    .req_low_i   (b_low_s),
    .h_o         (bh),
    .l_o         (bl),
    .dead_next_o (b_dead_next_s)
  );

  // Busy flag registered alongside the gates so it lines up with them
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= a_dead_next_s | b_dead_next_s;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_hbridge_driver.sv
// Directed bench for hbridge_driver with DEAD_CYCLES=4. Expected gate/busy
// vectors {ah,al,bh,bl,busy} are queued when each step is driven and popped
// when the DUT output for that step is sampled.

module tb_hbridge_driver;

  logic clk = 1'b0;
  logic clr, pwm, en, dir, brake;
  logic ah, al, bh, bl, busy;

  int errors = 0;
  int checks = 0;
  logic [4:0] sb[$];

  hbridge_driver #(.DEAD_CYCLES(4)) dut (
    .clk   (clk),
    .clr   (clr),
    .pwm   (pwm),
    .en    (en),
    .dir   (dir),
    .brake (brake),
    .ah    (ah),
    .al    (al),
    .bh    (bh),
    .bl    (bl),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [4:0] exp, input string tag);
    logic [4:0] got;
    got = {ah, al, bh, bl, busy};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got ah,al,bh,bl,busy=%b expected=%b", tag, got, exp);
    end
    checks++;
    assert ((!(ah && al) && !(bh && bl)) === 1'b1) else begin
      errors++;
      $error("FAIL %s_shoot: got ah,al,bh,bl=%b expected no leg with both gates on", tag, got[4:1]);
    end
  endtask

  // Called at a negedge: drive inputs, queue expectation, sample after posedge
  task automatic cyc(input logic p, input logic e, input logic d, input logic b,
                     input logic [4:0] exp, input string tag);
    logic [4:0] want;
    pwm = p; en = e; dir = d; brake = b;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL %s: got empty scoreboard expected one entry", tag);
    end else begin
      want = sb.pop_front();
      chk(want, tag);
    end
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0; pwm = 1'b0; en = 1'b0; dir = 1'b0; brake = 1'b0;
    #2;
    chk(5'b00000, "reset");
    @(negedge clk);
    clr = 1'b1;

    // Forward run: A high, B low, no dead period from OFF
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'b10010, "fwd_on");
    // pwm falls: A dead 4 cycles, then low; B low throughout
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'b00011, "pwm_fall_dead");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'b01010, "pwm_fall_low");
    // One-cycle high pulse on A in LOW is absorbed by DEAD, returns to LOW
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'b00011, "pulse_dead0");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'b00011, "pulse_dead");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'b01010, "pulse_back_low");
    // Back to high: LOW->HIGH also goes through DEAD
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'b00011, "rise_dead");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'b10010, "rise_high");
    // Direction reversal: both legs dead, then A low / B high
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'b00001, "rev_dead");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'b01100, "rev_run");
    // Brake: B leaves HIGH through DEAD, A stays low
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 5'b01001, "brake_dead");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 5'b01010, "brake_on");
    // Forward again from brake
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'b00011, "fwd2_dead");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'b10010, "fwd2_high");
    // Disable: both legs dead then OFF; re-enable has no dead period
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 5'b00001, "dis_dead");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, "dis_off");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, "dis_off_hold");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'b10010, "reen_fwd");
    // Reset mid-DEAD (counter=2) aborts at once
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'b00011, "pre_rst_dead0");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'b00011, "pre_rst_dead1");
    pwm = 1'b1;
    #1;
    clr = 1'b0;
    #1;
    chk(5'b00000, "async_clr");
    @(posedge clk);
    #1;
    chk(5'b00000, "clr_held");
    @(negedge clk);
    clr = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'b10010, "post_rst_fwd");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'b10010, "post_rst_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
